// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter. Sends one frame per accepted request,
// with bit timing paced by the external baud-oversampling tick.
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICKS   = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_tx_signal,
  input  logic [DATA_BITS-1:0] i_data_byte,
  output logic                 o_busy,
  output logic                 o_done_bit,
  output logic                 o_tx_data
);

  localparam int TW = (SB_TICKS > 1) ? $clog2(SB_TICKS) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SB_TICKS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    logic odd;
    odd = (PARITY_ODD != 0);
    return (^word) ^ odd;
  endfunction

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_end;

  // Next-state, counters and registered line value
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bit_end = i_tick && (tick_q == TICK_LAST);

    if (state_q != S_IDLE && i_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        idx_d  = '0;
        // busy stays up for the cycle after done, so requests there are dropped
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (i_tx_signal) begin
          shreg_d = i_data_byte;
          par_d   = calc_parity(i_data_byte);
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_tx_data  = tx_q;
  assign o_busy     = busy_q;
  assign o_done_bit = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed, table-driven bench for uart_tx_cfg in four configurations.
module tb_uart_tx_cfg;

  typedef struct {
    int   f;
    int   slot;
    logic exp;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] req   = 4'b0000;
  logic [7:0] data8 = 8'h00;
  logic [6:0] data7 = 7'h00;
  logic [3:0] tx, busy, done;

  int   tests = 0;
  int   fails = 0;
  int   phase = 0;
  logic tick_en = 1'b1;

  logic line_log [8][1024];
  int   exp_done [8];
  int   done_at  [8];
  int   done_cnt [8];
  int   stall_f  [8];
  vec_t vecs [$];

  always #5 clk = ~clk;

  uart_tx_cfg u_def (.i_clock(clk), .i_reset(rst), .i_tick(tick), .i_tx_signal(req[0]),
    .i_data_byte(data8), .o_busy(busy[0]), .o_done_bit(done[0]), .o_tx_data(tx[0]));
  uart_tx_cfg #(.PARITY_ODD(1)) u_odd (.i_clock(clk), .i_reset(rst), .i_tick(tick),
    .i_tx_signal(req[1]), .i_data_byte(data8), .o_busy(busy[1]), .o_done_bit(done[1]),
    .o_tx_data(tx[1]));
  uart_tx_cfg #(.PARITY_EN(0)) u_nop (.i_clock(clk), .i_reset(rst), .i_tick(tick),
    .i_tx_signal(req[2]), .i_data_byte(data8), .o_busy(busy[2]), .o_done_bit(done[2]),
    .o_tx_data(tx[2]));
  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_d7 (.i_clock(clk), .i_reset(rst),
    .i_tick(tick), .i_tx_signal(req[3]), .i_data_byte(data7), .o_busy(busy[3]),
    .o_done_bit(done[3]), .o_tx_data(tx[3]));

  // One clock: tick on every fourth edge, outputs sampled 1 ns after the edge
  task automatic cycle();
    tick = tick_en && (phase == 3);
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected line per bit slot: start, data LSB first, optional parity, stop bits
  task automatic add_word(input int f, input int n, input logic [8:0] w, input int par,
                          input int nstop);
    vec_t v;
    v.f = f; v.slot = 0; v.exp = 1'b0; vecs.push_back(v);
    for (int i = 0; i < n; i++) begin
      v.slot = i + 1; v.exp = w[i]; vecs.push_back(v);
    end
    if (par >= 0) begin
      v.slot = n + 1; v.exp = par[0]; vecs.push_back(v);
    end
    for (int s = 0; s < nstop; s++) begin
      v.slot = n + 1 + ((par >= 0) ? 1 : 0) + s; v.exp = 1'b1; vecs.push_back(v);
    end
  endtask

  task automatic run_frame(input int f, input int d, input logic [8:0] w, input int mid_req,
                           input bit done_req, input int rst_at, input int budget);
    while (phase != 3) cycle();
    data8 = w[7:0];
    data7 = w[6:0];
    req[d] = 1'b1;
    cycle();
    req[d] = 1'b0;
    data8 = ~w[7:0];
    data7 = ~w[6:0];
    line_log[f][0] = tx[d];
    chk($sformatf("f%0d_accept_busy", f), int'(busy[d]), 1);
    chk($sformatf("f%0d_accept_line", f), int'(tx[d]), 0);
    done_at[f]  = -1;
    done_cnt[f] = 0;
    for (int c = 1; c <= budget; c++) begin
      if (c == mid_req) req[d] = 1'b1;
      if (done_req && done_at[f] >= 0 && c == done_at[f] + 1) req[d] = 1'b1;
      if (c == rst_at) rst = 1'b1;
      if (c == stall_f[f]) tick_en = 1'b0;
      if (stall_f[f] >= 0 && c == stall_f[f] + 200) tick_en = 1'b1;
      cycle();
      req[d] = 1'b0;
      rst    = 1'b0;
      line_log[f][c] = tx[d];
      if (c == rst_at) begin
        chk($sformatf("f%0d_rst_line", f), int'(tx[d]), 1);
        chk($sformatf("f%0d_rst_busy", f), int'(busy[d]), 0);
        chk($sformatf("f%0d_rst_done", f), int'(done[d]), 0);
      end
      if (done[d]) begin
        done_cnt[f]++;
        if (done_at[f] < 0) done_at[f] = c;
      end
      if (done_at[f] >= 0 && c == done_at[f]) begin
        chk($sformatf("f%0d_busy_in_done", f), int'(busy[d]), 1);
      end
      if (done_at[f] >= 0 && c == done_at[f] + 1) begin
        chk($sformatf("f%0d_busy_after_done", f), int'(busy[d]), 0);
        break;
      end
    end
    chk($sformatf("f%0d_done_latency", f), done_at[f], exp_done[f]);
    chk($sformatf("f%0d_done_pulses", f), done_cnt[f], (exp_done[f] >= 0) ? 1 : 0);
  endtask

  initial begin
    int c;
    int lat;

    exp_done = '{704, 704, 640, 704, 704, -1, 704, 904};
    stall_f  = '{-1, -1, -1, -1, -1, -1, -1, 266};
    add_word(0, 8, 9'h0AA, 0, 1);
    add_word(1, 8, 9'h0AA, 1, 1);
    add_word(2, 8, 9'h0AA, -1, 1);
    add_word(3, 7, 9'h055, 0, 2);
    add_word(4, 8, 9'h03C, 0, 1);
    add_word(6, 8, 9'h007, 1, 1);
    add_word(7, 8, 9'h0AA, 0, 1);

    rst = 1'b1;
    repeat (4) cycle();
    rst = 1'b0;
    cycle();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_line%0d", d), int'(tx[d]), 1);
      chk($sformatf("reset_busy%0d", d), int'(busy[d]), 0);
      chk($sformatf("reset_done%0d", d), int'(done[d]), 0);
    end

    run_frame(0, 0, 9'h0AA, -1, 1'b0, -1, 800);
    run_frame(1, 1, 9'h0AA, -1, 1'b0, -1, 800);
    run_frame(2, 2, 9'h0AA, -1, 1'b0, -1, 800);
    run_frame(3, 3, 9'h055, -1, 1'b0, -1, 800);

    // Requests mid-frame and during done are dropped; the next clock starts a frame
    run_frame(4, 0, 9'h03C, 300, 1'b1, -1, 800);
    data8  = 8'hF0;
    req[0] = 1'b1;
    cycle();
    req[0] = 1'b0;
    chk("b2b_start_line", int'(tx[0]), 0);
    chk("b2b_start_busy", int'(busy[0]), 1);
    // Accepted two clocks past a tick edge, so the first counted tick is 2 clocks later
    lat = -1;
    for (int k = 1; k <= 800; k++) begin
      cycle();
      if (done[0]) begin
        lat = k;
        break;
      end
    end
    chk("b2b_done_latency", lat, 702);
    repeat (2) cycle();

    run_frame(5, 0, 9'h05A, -1, 1'b0, 280, 800);
    run_frame(6, 0, 9'h007, -1, 1'b0, -1, 800);
    run_frame(7, 0, 9'h0AA, -1, 1'b0, -1, 1000);
    chk("stall_line_held", int'(line_log[7][366]), 1);

    foreach (vecs[i]) begin
      c = 64 * vecs[i].slot + 32;
      if (stall_f[vecs[i].f] >= 0 && c > stall_f[vecs[i].f]) c = c + 200;
      chk($sformatf("f%0d_slot%0d", vecs[i].f, vecs[i].slot),
          int'(line_log[vecs[i].f][c]), int'(vecs[i].exp));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
